// File: rtl/slice_ser_pkg.sv
// rtl/slice_ser_pkg.sv - shared types and elaboration helpers for the slice serializer
//
// Holds the two-state FSM encoding and the functions that derive the beat
// count and beat-index width from WIDTH/CHUNK. The same helpers are used by
// slice_mux so that the serializer and any future deserializer agree on them.

package slice_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Number of CHUNK-bit beats in a WIDTH-bit word.
  function automatic int beats_of(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  // Beat index width; a single-beat word still gets a 1-bit index.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Legal configuration: 1 <= CHUNK <= WIDTH and WIDTH a multiple of CHUNK.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/slice_mux.sv
// rtl/slice_mux.sv - combinational CHUNK-slice selector over a WIDTH-bit word
//
// Ports:
//   word      : WIDTH-bit source word
//   idx       : beat number k, counting from 0
//   msb_first : 1 maps beat 0 to the top slice, 0 maps beat 0 to the bottom slice
//   slice     : selected CHUNK-bit slice

module slice_mux
  import slice_ser_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  localparam int BEATS = beats_of(WIDTH, CHUNK),
  localparam int CW    = idx_width(BEATS)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [CW-1:0]    idx,
  input  logic             msb_first,
  output logic [CHUNK-1:0] slice
);

  logic [CW-1:0] sel;

  always_comb begin
    // MSB-first simply mirrors the beat number onto the slice position.
    sel   = msb_first ? (CW'(BEATS - 1) - idx) : idx;
    slice = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (sel == CW'(i)) begin
        slice = word[i*CHUNK +: CHUNK];
      end
    end
  end

endmodule

// File: rtl/slice_serializer.sv
// rtl/slice_serializer.sv - WIDTH-to-CHUNK width-down converter with per-word beat order
//
// Accepts one WIDTH-bit word on the in_* handshake and replays it as BEATS
// CHUNK-bit slices on the out_* handshake, LSB-first or MSB-first per word.
//
// Ports:
//   clk, arst_n     : rising-edge clock, asynchronous active-low reset
//   in_valid/ready  : word handshake; in_data + in_msb_first sampled on accept
//   out_valid/ready : slice handshake
//   out_data        : current slice (registered)
//   out_last        : current slice is the final beat of its word (registered)
//   out_idx         : beat number within the word (registered)

module slice_serializer
  import slice_ser_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  localparam int BEATS = beats_of(WIDTH, CHUNK),
  localparam int CW    = idx_width(BEATS)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic [CW-1:0]    out_idx
);

  generate
    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("slice_serializer: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  ser_state_t       state, nxt_state;
  logic [WIDTH-1:0] word_q, nxt_word;
  logic             msb_q, nxt_msb;
  logic [CW-1:0]    beat_q, nxt_beat;
  logic [CHUNK-1:0] nxt_slice;

  logic last_beat;
  logic accept;
  logic out_hs;

  assign last_beat = (state == SEND) && (beat_q == LAST_IDX);

  // Ready in IDLE, or on the last beat when that beat is being taken so the
  // next word can load in the same edge (no bubble between words).
  assign in_ready  = arst_n && ((state == IDLE) || (last_beat && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_hs    = (state == SEND) && out_ready;

  assign out_valid = (state == SEND);
  assign out_idx   = beat_q;

  always_comb begin
    nxt_state = state;
    nxt_word  = word_q;
    nxt_msb   = msb_q;
    nxt_beat  = beat_q;
    if (accept) begin
      nxt_state = SEND;
      nxt_word  = in_data;
      nxt_msb   = in_msb_first;
      nxt_beat  = '0;
    end else if (out_hs) begin
      if (last_beat) begin
        nxt_state = IDLE;
        nxt_beat  = '0;
      end else begin
        nxt_beat  = beat_q + CW'(1);
      end
    end
  end

  // The slice is selected from next-state values so out_data can be a plain
  // register and still present beat 0 one cycle after accept.
  slice_mux #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_slice_mux (
    .word      (nxt_word),
    .idx       (nxt_beat),
    .msb_first (nxt_msb),
    .slice     (nxt_slice)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      word_q   <= '0;
      msb_q    <= 1'b0;
      beat_q   <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state    <= nxt_state;
      word_q   <= nxt_word;
      msb_q    <= nxt_msb;
      beat_q   <= nxt_beat;
      out_data <= (nxt_state == SEND) ? nxt_slice : '0;
      out_last <= (nxt_state == SEND) && (nxt_beat == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_slice_serializer.sv
// tb/tb_slice_serializer.sv - directed self-checking bench for slice_serializer

module tb_slice_serializer;

  logic        clk;
  logic        arst_n;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_msb_first;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_last;
  logic [1:0]  out_idx;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic        b_in_msb_first;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_data;
  logic        b_out_last;
  logic [0:0]  b_out_idx;

  int tests_run = 0;
  int tests_failed = 0;

  slice_serializer #(.WIDTH(16), .CHUNK(4)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_idx      (out_idx)
  );

  slice_serializer #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk          (clk),
    .arst_n       (arst_n),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .in_data      (b_in_data),
    .in_msb_first (b_in_msb_first),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .out_data     (b_out_data),
    .out_last     (b_out_last),
    .out_idx      (b_out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one in-flight beat of the 16/4 instance at the current negedge.
  task automatic check_beat(input string tag, input logic [3:0] data, input int k, input logic rdy);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " data"},  32'(out_data),  32'(data));
    check({tag, " idx"},   32'(out_idx),   32'(k));
    check({tag, " last"},  32'(out_last),  32'(k == 3));
    check({tag, " rdy"},   32'(in_ready),  32'(rdy));
  endtask

  // seq[15:12] is the expected first beat, seq[3:0] the last.
  task automatic run_word(input string tag, input logic [15:0] d, input logic m, input logic [15:0] seq);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_msb_first = m; out_ready = 1'b1;
    #1 check({tag, " accept rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      check_beat($sformatf("%s b%0d", tag, k), seq[15-4*k -: 4], k, k == 3);
      @(negedge clk);
    end
    check({tag, " done valid"}, 32'(out_valid), 32'd0);
    check({tag, " done rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    arst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_msb_first = 1'b0; b_out_ready = 1'b0;

    #2;
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst last",  32'(out_last),  32'd0);
    check("rst idx",   32'(out_idx),   32'd0);
    check("rst data",  32'(out_data),  32'd0);
    check("rst rdy",   32'(in_ready),  32'd0);
    check("rst b rdy", 32'(b_in_ready), 32'd0);

    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1 check("post rst rdy", 32'(in_ready), 32'd1);

    // Basic LSB-first and MSB-first.
    run_word("lsb", 16'hA5C3, 1'b0, 16'h3C5A);
    run_word("msb", 16'h1234, 1'b1, 16'h1234);

    // Stall at beat 2 of BEEF.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hBEEF; in_msb_first = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_beat("stl b0", 4'hF, 0, 1'b0);
    @(negedge clk);
    check_beat("stl b1", 4'hE, 1, 1'b0);
    @(negedge clk);
    check_beat("stl b2", 4'hE, 2, 1'b0);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_beat("stl hold", 4'hE, 2, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_beat("stl b3", 4'hB, 3, 1'b1);
    @(negedge clk);
    check("stl done valid", 32'(out_valid), 32'd0);

    // Back-to-back words with in_valid held high.
    in_valid = 1'b1; in_data = 16'h00FF; in_msb_first = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_data = 16'hF00F;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] seq;
      seq = 32'hFF00F00F;
      check_beat($sformatf("b2b %0d", i), seq[31-4*i -: 4], i % 4, (i % 4) == 3);
      @(negedge clk);
      if (i == 3) in_valid = 1'b0;
    end
    check("b2b done valid", 32'(out_valid), 32'd0);

    // Reset in the middle of CAFE.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hCAFE; in_msb_first = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_beat("rmw b0", 4'hE, 0, 1'b0);
    @(negedge clk);
    check_beat("rmw b1", 4'hF, 1, 1'b0);
    arst_n = 1'b0;
    #1;
    check("rmw async valid", 32'(out_valid), 32'd0);
    check("rmw async idx",   32'(out_idx),   32'd0);
    check("rmw async rdy",   32'(in_ready),  32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("rmw rel rdy",   32'(in_ready),  32'd1);
    check("rmw rel valid", 32'(out_valid), 32'd0);
    run_word("after rst", 16'h0001, 1'b0, 16'h1000);

    // Degenerate WIDTH=8, CHUNK=8: one word per cycle.
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 8'h5A; b_out_ready = 1'b1;
    #1 check("deg rdy0", 32'(b_in_ready), 32'd1);
    @(negedge clk);
    b_in_data = 8'hC3;
    check("deg w0 valid", 32'(b_out_valid), 32'd1);
    check("deg w0 data",  32'(b_out_data),  32'h5A);
    check("deg w0 last",  32'(b_out_last),  32'd1);
    check("deg w0 idx",   32'(b_out_idx),   32'd0);
    check("deg w0 rdy",   32'(b_in_ready),  32'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    check("deg w1 valid", 32'(b_out_valid), 32'd1);
    check("deg w1 data",  32'(b_out_data),  32'hC3);
    check("deg w1 last",  32'(b_out_last),  32'd1);
    check("deg w1 idx",   32'(b_out_idx),   32'd0);
    @(negedge clk);
    check("deg done valid", 32'(b_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
